// File: rtl/command_fifo_param.sv
// Parametrised single-clock command FIFO with show-ahead read, occupancy count and almost flags.
// Optional sticky overflow/underflow flags are built only when COMMAND_FIFO_ERR_FLAGS_EN is defined.
module command_fifo_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int ADDR    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             write_command,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read_command,
  output logic [WIDTH-1:0] read_data,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [ADDR:0]    count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ADDR-1:0] PTR_ZERO_C = ADDR'(0);
  localparam logic [ADDR-1:0] PTR_ONE_C  = ADDR'(1);
  localparam logic [ADDR:0]   CNT_ZERO_C = (ADDR + 1)'(0);
  localparam logic [ADDR:0]   CNT_ONE_C  = (ADDR + 1)'(1);
  localparam logic [ADDR:0]   CNT_FULL_C = (ADDR + 1)'(DEPTH);
  localparam logic [ADDR:0]   AF_LVL_C   = (ADDR + 1)'(AF_LEVEL);
  localparam logic [ADDR:0]   AE_LVL_C   = (ADDR + 1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR-1:0]  wptr_r;
  logic [ADDR-1:0]  rptr_r;
  logic [ADDR:0]    count_r;
  logic [ADDR:0]    count_nxt_s;
  logic             push_acc_s;
  logic             pop_acc_s;

  // Status decodes all derive from the registered occupancy.
  assign fifo_empty   = (count_r == CNT_ZERO_C);
  assign fifo_full    = (count_r == CNT_FULL_C);
  assign almost_full  = (count_r >= AF_LVL_C);
  assign almost_empty = (count_r <= AE_LVL_C);
  assign count        = count_r;

  // Accept decisions use current-cycle full/empty, so full+both pops only and empty+both pushes only.
  assign push_acc_s = write_command && !fifo_full && !flush;
  assign pop_acc_s  = read_command && !fifo_empty && !flush;

  // Next occupancy from accepted push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_acc_s, pop_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE_C;
      2'b01:   count_nxt_s = count_r - CNT_ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Show-ahead head word, forced to zero when empty so stale storage never leaks out.
  always_comb begin
    read_data = {WIDTH{1'b0}};
    if (fifo_empty) begin
      read_data = {WIDTH{1'b0}};
    end else begin
      read_data = mem_r[rptr_r];
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_acc_s) begin
      mem_r[wptr_r] <= write_data;
    end
  end

  // Pointer and occupancy registers; flush clears them but leaves storage untouched.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_r  <= PTR_ZERO_C;
      rptr_r  <= PTR_ZERO_C;
      count_r <= CNT_ZERO_C;
    end else if (flush) begin
      wptr_r  <= PTR_ZERO_C;
      rptr_r  <= PTR_ZERO_C;
      count_r <= CNT_ZERO_C;
    end else begin
      if (push_acc_s) begin
        wptr_r <= wptr_r + PTR_ONE_C;
      end
      if (pop_acc_s) begin
        rptr_r <= rptr_r + PTR_ONE_C;
      end
      count_r <= count_nxt_s;
    end
  end

`ifdef COMMAND_FIFO_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags, cleared only by reset or flush.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (write_command && fifo_full) begin
        overflow_r <= 1'b1;
      end
      if (read_command && fifo_empty) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
